// File: rtl/rf_write_scheduler.sv
// Register-file write-port owner: zeroing sweep of x1..x31 after reset, then round-robin write-back arbitration.
// Latency: gnt is combinational; the granted write appears on the registered write port one cycle later.
// Backpressure: requesters that lose arbitration see gnt=0 and keep req/rd/data stable until granted.
module rf_write_scheduler #(
    parameter int NREQ = 3,
    parameter int DW   = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_rd,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 RegWrite,
    output logic [AW-1:0]        Rd,
    output logic [DW-1:0]        Write_data,
    output logic                 init_done
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {INIT, RUN} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   sweep_cnt_q, sweep_cnt_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            regwrite_q, regwrite_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            init_done_q, init_done_d;

    logic            found;
    logic            gnt_vld;
    logic [AW-1:0]   sel_rd;
    logic [DW-1:0]   sel_data;
    logic [PW-1:0]   sel_nxt;

    // Round-robin grant: first requester at or above rr_ptr, else first one below it.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        if (!reset && state_q == RUN) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (i >= int'(rr_ptr_q))) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!found && req[i] && (i < int'(rr_ptr_q))) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

    // Mux the granted requester's destination, data and the pointer that follows it.
    always_comb begin
        gnt_vld  = |gnt;
        sel_rd   = '0;
        sel_data = '0;
        sel_nxt  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_rd   = req_rd[i*AW +: AW];
                sel_data = req_data[i*DW +: DW];
                sel_nxt  = (i == NREQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // Next-state: sweep one register per cycle in INIT, forward granted write-backs in RUN.
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        regwrite_d  = 1'b0;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        init_done_d = init_done_q;
        case (state_q)
            INIT: begin
                regwrite_d  = 1'b1;
                rd_d        = sweep_cnt_q;
                wdata_d     = '0;
                sweep_cnt_d = sweep_cnt_q + AW'(1);
                if (&sweep_cnt_q) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                if (gnt_vld) begin
                    // x0 writes are consumed but never reach the register file.
                    regwrite_d = |sel_rd;
                    rd_d       = sel_rd;
                    wdata_d    = sel_data;
                    rr_ptr_d   = sel_nxt;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State and write-port registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            sweep_cnt_q <= AW'(1);
            rr_ptr_q    <= '0;
            regwrite_q  <= 1'b0;
            rd_q        <= '0;
            wdata_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            regwrite_q  <= regwrite_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            init_done_q <= init_done_d;
        end
    end

    assign RegWrite   = regwrite_q;
    assign Rd         = rd_q;
    assign Write_data = wdata_q;
    assign init_done  = init_done_q;

endmodule
